mlp_layer_loader: RTL and testbench
===================================

Name: mlp_layer_loader

Overview:
Host-side initiator for the fully-connected MLP core. Parses one framed byte stream per layer (header, inputs, weights, biases) and drives the core's input/weight/bias write ports and its num_inputs/num_outputs configuration. Runs the core's start/done handshake, then captures the core's per-neuron output bytes into a small FIFO and presents them as a valid/ready result stream with a last marker. Sits between the host DMA/byte bridge and the MLP core.

Parameters:
FIFO_DEPTH, 16, result FIFO entries (power of two, >=2)
MAX_INPUTS, 4096, largest accepted num_inputs (core input buffer size)
MAX_OUTPUTS, 256, largest accepted num_outputs (core bias buffer size)
MAX_WEIGHTS, 16384, largest accepted num_inputs*num_outputs (core weight buffer size)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_data  in  8  command stream byte
s_valid  in  1  s_data valid
s_ready  out  1  loader accepts s_data
s_last  in  1  final byte of frame
cfg_num_inputs  out  16  to core num_inputs
cfg_num_outputs  out  16  to core num_outputs
input_addr / input_data / input_we  out  16/8/1  core input write port
weight_addr / weight_data / weight_we  out  16/8/1  core weight write port
bias_addr / bias_data / bias_we  out  16/8/1  core bias write port
core_start  out  1  core start level
core_done  in  1  core done level
core_out_data  in  8  core result byte
core_out_valid  in  1  core result strobe (1 cycle per neuron)
m_data  out  8  result byte
m_valid  out  1  result valid
m_ready  in  1  result consumer ready
m_last  out  1  with final result of the layer
busy  out  1  high in every state except IDLE
err_hdr / err_len / err_ovf  out  1 each  sticky error flags
clr_err  in  1  synchronous clear of all error flags

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0, cfg_* 0. Reset mid-frame or mid-run abandons everything; core_start drops immediately.
- Frame: 4 header bytes little-endian (NI lo, NI hi, NO lo, NO hi), then NI input bytes, NI*NO weight bytes row-major (byte k = neuron n, input i, k=n*NI+i), then NO bias bytes. Byte accepted when s_valid & s_ready.
- States: IDLE, HDR, LD_IN, LD_WT, LD_BIAS, RUN, REL, DRAIN.
- s_ready = 1 in IDLE, HDR, LD_*, DRAIN; 0 in RUN, REL.
- IDLE: accepted byte is header byte 0 -> HDR. HDR: after byte 3, cfg_* latched. Checks: 1<=NI<=MAX_INPUTS, 1<=NO<=MAX_OUTPUTS, NI*NO<=MAX_WEIGHTS (32-bit product). Fail -> set err_hdr, DRAIN (or IDLE if byte 3 carried s_last). Pass -> LD_IN.
- Load writes registered: *_we high exactly one cycle after acceptance, addr = 0-based index within that section, data = accepted byte. Address counters reset at each section start.
- LD_IN -> LD_WT after NI bytes; LD_WT -> LD_BIAS after NI*NO bytes; LD_BIAS -> RUN after NO bytes.
- s_last: must coincide with final bias byte. s_last earlier -> err_len, IDLE, no start. Final bias byte without s_last -> err_len, DRAIN, no start.
- DRAIN: accept and discard until s_last accepted -> IDLE.
- RUN: core_start = 1 from the cycle after entry until core_done seen high -> REL. REL: core_start = 0; wait core_done low -> IDLE.
- Capture: each core_out_valid (any state) pushes core_out_data into FIFO with a tag bit = (result count == NO-1); result counter cleared on RUN entry. FIFO full on push: byte dropped, err_ovf set.
- m_data/m_valid/m_last from FIFO head (first-word-fall-through); pop on m_valid & m_ready. Simultaneous push and pop when full: pop frees the slot, push succeeds.
- Next frame may start in IDLE while FIFO still holds results.
- clr_err clears flags; a same-cycle set wins.

Decomposition:
- Package mlp_pkg: loader state enum, header byte count constant (4), MAX_* defaults shared with the core.
- Sub-module: mlp_result_fifo (sync FWFT FIFO, width 9 = data + last tag, depth FIFO_DEPTH, full/empty, count).

Test Plan:
- Frame NI=3, NO=2, inputs 01 02 03, weights 10..15, biases 7F 80, s_last on 80 -> input_we addr 0..2, weight_we addr 0..5 data 10..15, bias_we addr 0,1, then core_start high until core_done.
- Core model returns 05, 00 -> m_data 05 (m_last 0), 00 (m_last 1); core_start low after done, busy low once core_done drops.
- Header NI=0 then 3 more bytes with s_last on 3rd -> err_hdr=1, no *_we, no core_start, s_ready high throughout, back to IDLE; clr_err -> err_hdr=0.
- NI=2, NO=1 frame with s_last on 2nd weight byte -> err_len=1, IDLE, core_start never asserted.
- FIFO_DEPTH=4, m_ready=0, core emits 6 results -> 4 held, err_ovf=1; release m_ready -> exactly 4 bytes out in order.
- Reset asserted during LD_WT -> all outputs 0 immediately; next full frame loads from weight addr 0 correctly.

Source files
------------

// File: rtl/mlp_pkg.sv
// mlp_pkg: loader state encoding and buffer limits shared with the MLP core
package mlp_pkg;
  typedef enum logic [2:0] {IDLE, HDR, LD_IN, LD_WT, LD_BIAS, RUN, REL, DRAIN} ld_state_e;
  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned MAX_INPUTS_DEF = 4096;
  localparam int unsigned MAX_OUTPUTS_DEF = 256;
  localparam int unsigned MAX_WEIGHTS_DEF = 16384;
endpackage

// File: rtl/mlp_result_fifo.sv
// mlp_result_fifo: first-word-fall-through result FIFO; a pop frees room for a same-cycle push when full
module mlp_result_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o = mem_q[rd_q];
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_q + AW'(do_pop);
      wr_q <= wr_q + AW'(do_push);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage array, contents need no reset
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/mlp_layer_loader.sv
// mlp_layer_loader: parses a layer frame into core buffer writes, runs the core, streams results out
module mlp_layer_loader import mlp_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_INPUTS = MAX_INPUTS_DEF,
  parameter int unsigned MAX_OUTPUTS = MAX_OUTPUTS_DEF,
  parameter int unsigned MAX_WEIGHTS = MAX_WEIGHTS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic [15:0] cfg_num_inputs,
  output logic [15:0] cfg_num_outputs,
  output logic [15:0] input_addr,
  output logic [7:0]  input_data,
  output logic        input_we,
  output logic [15:0] weight_addr,
  output logic [7:0]  weight_data,
  output logic        weight_we,
  output logic [15:0] bias_addr,
  output logic [7:0]  bias_data,
  output logic        bias_we,
  output logic        core_start,
  input  logic        core_done,
  input  logic [7:0]  core_out_data,
  input  logic        core_out_valid,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        err_hdr,
  output logic        err_len,
  output logic        err_ovf,
  input  logic        clr_err
);
  ld_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d, wt_q, wt_d, sec_len, hdr_prod;
  logic [23:0] hdr_q, hdr_d;
  logic [15:0] ni_q, ni_d, no_q, no_d, res_q, res_d, addr_q, addr_d, hdr_ni, hdr_no;
  logic [7:0] data_q, data_d;
  logic [2:0] we_q, we_d, err_q, err_d;
  logic start_q, start_d, rdy_q, rdy_d;
  logic acc, sec_end, hdr_ok, set_hdr, set_len, pop, f_full, f_empty;
  logic [8:0] f_dout;
  assign acc = s_valid & s_ready;
  assign hdr_ni = hdr_q[15:0];
  assign hdr_no = {s_data, hdr_q[23:16]};
  assign hdr_prod = {16'd0, hdr_ni} * {16'd0, hdr_no};
  assign hdr_ok = hdr_ni != 16'd0 && 32'(hdr_ni) <= MAX_INPUTS && hdr_no != 16'd0 &&
                  32'(hdr_no) <= MAX_OUTPUTS && hdr_prod <= MAX_WEIGHTS;
  assign sec_len = state_q == LD_WT ? wt_q : {16'd0, state_q == LD_IN ? ni_q : no_q};
  assign sec_end = cnt_q == sec_len - 32'd1;
  assign pop = m_valid & m_ready;
  // frame parser and core handshake sequencing
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hdr_d = hdr_q;
    ni_d = ni_q;
    no_d = no_q;
    wt_d = wt_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d = '0;
    set_hdr = 1'b0;
    set_len = 1'b0;
    case (state_q)
      IDLE, HDR: if (acc) begin
        hdr_d = {s_data, hdr_q[23:8]};
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == HDR_BYTES - 1) begin
          ni_d = hdr_ni;
          no_d = hdr_no;
          wt_d = hdr_prod;
          set_hdr = ~hdr_ok;
          set_len = hdr_ok & s_last;
          state_d = s_last ? IDLE : hdr_ok ? LD_IN : DRAIN;
          cnt_d = '0;
        end else begin
          set_len = s_last;
          state_d = s_last ? IDLE : HDR;
        end
      end
      LD_IN, LD_WT, LD_BIAS: if (acc) begin
        we_d = {state_q == LD_BIAS, state_q == LD_WT, state_q == LD_IN};
        addr_d = cnt_q[15:0];
        data_d = s_data;
        cnt_d = sec_end ? '0 : cnt_q + 32'd1;
        if (sec_end) state_d = state_q == LD_IN ? LD_WT : state_q == LD_WT ? LD_BIAS : s_last ? RUN : DRAIN;
        if (s_last && !(sec_end && state_q == LD_BIAS)) state_d = IDLE;
        set_len = s_last != (sec_end && state_q == LD_BIAS);
      end
      DRAIN: if (acc && s_last) state_d = IDLE;
      RUN: if (core_done) state_d = REL;
      REL: if (!core_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) cnt_d = '0;
  end
  // handshake, result tagging and sticky error next-state
  always_comb begin
    start_d = state_q == RUN && !core_done;
    rdy_d = !(state_d inside {RUN, REL});
    res_d = (state_d == RUN && state_q != RUN) ? '0 : res_q + 16'(core_out_valid);
    err_d = (err_q & {3{~clr_err}}) | {core_out_valid & f_full & ~pop, set_len, set_hdr};
  end
  // all loader state, cleared asynchronously so a reset abandons any frame or run
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wt_q <= '0;
      hdr_q <= '0;
      ni_q <= '0;
      no_q <= '0;
      res_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= '0;
      err_q <= '0;
      start_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wt_q <= wt_d;
      hdr_q <= hdr_d;
      ni_q <= ni_d;
      no_q <= no_d;
      res_q <= res_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
      err_q <= err_d;
      start_q <= start_d;
      rdy_q <= rdy_d;
    end
  mlp_result_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(core_out_valid),
    .din_i({res_q == no_q - 16'd1, core_out_data}),
    .pop_i(pop),
    .dout_o(f_dout),
    .full_o(f_full),
    .empty_o(f_empty)
  );
  assign s_ready = rdy_q;
  assign cfg_num_inputs = ni_q;
  assign cfg_num_outputs = no_q;
  assign input_addr = addr_q;
  assign weight_addr = addr_q;
  assign bias_addr = addr_q;
  assign input_data = data_q;
  assign weight_data = data_q;
  assign bias_data = data_q;
  assign input_we = we_q[0];
  assign weight_we = we_q[1];
  assign bias_we = we_q[2];
  assign core_start = start_q;
  assign busy = state_q != IDLE;
  assign err_hdr = err_q[0];
  assign err_len = err_q[1];
  assign err_ovf = err_q[2];
  assign m_valid = ~f_empty;
  assign m_data = m_valid ? f_dout[7:0] : 8'd0;
  assign m_last = m_valid & f_dout[8];
endmodule

// File: tb/tb_mlp_layer_loader.sv
// tb_mlp_layer_loader: directed frames with write and result scoreboards
module tb_mlp_layer_loader;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] s_data, input_data, weight_data, bias_data, core_out_data, m_data;
  logic s_valid, s_ready, s_last, input_we, weight_we, bias_we, core_start, core_done;
  logic core_out_valid, m_valid, m_ready, m_last, busy, err_hdr, err_len, err_ovf, clr_err;
  logic [15:0] cfg_num_inputs, cfg_num_outputs, input_addr, weight_addr, bias_addr;
  int total = 0, bad = 0;
  logic [25:0] wq[$];
  logic [8:0] rq[$];

  always #5 clk = ~clk;

  mlp_layer_loader #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .cfg_num_inputs(cfg_num_inputs), .cfg_num_outputs(cfg_num_outputs),
    .input_addr(input_addr), .input_data(input_data), .input_we(input_we),
    .weight_addr(weight_addr), .weight_data(weight_data), .weight_we(weight_we),
    .bias_addr(bias_addr), .bias_data(bias_data), .bias_we(bias_we),
    .core_start(core_start), .core_done(core_done), .core_out_data(core_out_data),
    .core_out_valid(core_out_valid), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .err_hdr(err_hdr), .err_len(err_len), .err_ovf(err_ovf),
    .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wchk(input logic [25:0] o);
    if (wq.size() == 0) chk("wr_unexp", wq.size(), 1);
    else chk("wr", o, wq.pop_front());
  endtask

  always @(negedge clk) if (rst_n) begin
    if (input_we) wchk({2'd0, input_addr, input_data});
    if (weight_we) wchk({2'd1, weight_addr, weight_data});
    if (bias_we) wchk({2'd2, bias_addr, bias_data});
    if (m_valid && m_ready) begin
      if (rq.size() == 0) chk("res_unexp", rq.size(), 1);
      else chk("res", {m_last, m_data}, rq.pop_front());
    end
  end

  function automatic logic [7:0] fbyte(int ni, int no, int idx);
    int k = idx - 4;
    case (idx)
      0: return ni[7:0];
      1: return ni[15:8];
      2: return no[7:0];
      3: return no[15:8];
      default: return k < ni ? 8'(k + 1) : k < ni + ni * no ? 8'(16 + k - ni) : 8'(127 + k - ni - ni * no);
    endcase
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input bit strict);
    int n = 0;
    bit ok = 0;
    s_data = b;
    s_valid = 1'b1;
    s_last = last;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_ready;
      n++;
      cyc();
    end
    if (!ok) chk("send_timeout", {31'd0, s_ready}, 1);
    if (strict) chk("rdy_thru", n, 1);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic frame(input int ni, input int no, input int stop, input bit last, input bit strict);
    int k, a;
    logic [1:0] p;
    for (int i = 0; i <= stop; i++) begin
      if (i >= 4) begin
        k = i - 4;
        p = k < ni ? 2'd0 : k < ni + ni * no ? 2'd1 : 2'd2;
        a = k < ni ? k : k < ni + ni * no ? k - ni : k - ni - ni * no;
        wq.push_back({p, 16'(a), fbyte(ni, no, i)});
      end
      send(fbyte(ni, no, i), last && i == stop, strict);
    end
  endtask

  task automatic run_core(input int n, input logic [7:0] base, input int keep, input int no);
    bit seen = 0;
    logic [7:0] d;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      seen = core_start;
      cyc();
    end
    chk("start_hi", {31'd0, seen}, 1);
    for (int i = 0; i < n; i++) begin
      d = 8'(base - 5 * i);
      if (i < keep) rq.push_back({i == no - 1, d});
      core_out_data = d;
      core_out_valid = 1'b1;
      cyc();
    end
    core_out_valid = 1'b0;
    core_out_data = 8'd0;
    @(negedge clk);
    chk("start_hold", {31'd0, core_start}, 1);
    cyc();
    core_done = 1'b1;
    cyc();
    @(negedge clk);
    chk("start_lo", {31'd0, core_start}, 0);
    chk("rel_busy", {31'd0, busy}, 1);
    cyc();
    core_done = 1'b0;
    cyc();
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    cyc();
  endtask

  task automatic clr_pulse;
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    s_data = 0; s_valid = 0; s_last = 0; core_done = 0; core_out_data = 0;
    core_out_valid = 0; m_ready = 1; clr_err = 0;
    #2;
    chk("rst_ctl", {s_ready, busy, core_start, m_valid, m_last, input_we, weight_we, bias_we, err_hdr, err_len, err_ovf}, 0);
    chk("rst_cfg", {cfg_num_inputs, cfg_num_outputs}, 0);
    cyc();
    rst_n = 1'b1;
    // normal layer: NI=3 NO=2
    frame(3, 2, 14, 1, 0);
    chk("cfg_ni", cfg_num_inputs, 3);
    chk("cfg_no", cfg_num_outputs, 2);
    chk("run_busy", {31'd0, busy}, 1);
    chk("run_rdy", {31'd0, s_ready}, 0);
    run_core(2, 8'h05, 2, 2);
    repeat (4) cyc();
    chk("t1_drained", rq.size(), 0);
    chk("t1_err", {err_hdr, err_len, err_ovf}, 0);
    // bad header NI=0, s_last on byte 3
    frame(0, 1, 3, 1, 1);
    @(negedge clk);
    chk("hdr_err", {err_hdr, err_len}, 2'b10);
    chk("hdr_idle", {31'd0, busy}, 0);
    chk("hdr_start", {31'd0, core_start}, 0);
    chk("hdr_rdy", {31'd0, s_ready}, 1);
    cyc();
    clr_pulse();
    @(negedge clk);
    chk("hdr_clr", {31'd0, err_hdr}, 0);
    cyc();
    // early s_last on final weight byte
    frame(2, 1, 7, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len_nostart", {31'd0, core_start}, 0);
      cyc();
    end
    chk("len_err", {err_hdr, err_len}, 2'b01);
    chk("len_idle", {31'd0, busy}, 0);
    clr_pulse();
    // overflow: 6 results into a 4-deep FIFO with consumer stalled
    m_ready = 1'b0;
    frame(1, 6, 16, 1, 0);
    run_core(6, 8'hA0, 4, 6);
    @(negedge clk);
    chk("ovf_err", {31'd0, err_ovf}, 1);
    chk("ovf_held", {31'd0, m_valid}, 1);
    chk("ovf_head", m_data, 8'hA0);
    cyc();
    m_ready = 1'b1;
    repeat (8) cyc();
    chk("ovf_drained", rq.size(), 0);
    chk("ovf_empty", {31'd0, m_valid}, 0);
    clr_pulse();
    // reset during weight load, then a fresh frame
    frame(2, 2, 6, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {s_ready, busy, core_start, m_valid, input_we, weight_we, bias_we, err_hdr, err_len, err_ovf}, 0);
    chk("mid_rst_cfg", {cfg_num_inputs, cfg_num_outputs}, 0);
    chk("mid_rst_wq", wq.size(), 0);
    cyc();
    rst_n = 1'b1;
    frame(1, 1, 6, 1, 0);
    run_core(1, 8'h33, 1, 1);
    repeat (4) cyc();
    chk("final_wq", wq.size(), 0);
    chk("final_rq", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
